// File: rtl/tdm_demux16_if.sv
// tdm_demux16_if
// Bundles the serial TDM stream and the demultiplexer's results into one
// interface.
//
// Signals:
//   din         serial data, one channel bit per valid slot
//   din_valid   qualifies din and sync
//   sync        marks the channel-0 slot of a frame
//   ch_out      last good frame, bit n = channel n
//   frame_valid one-cycle pulse when ch_out updates
//   sel         slot index expected on the next valid beat
//   sync_err    one-cycle pulse on a framing violation
//   parity_err  one-cycle pulse on a parity failure
//
// Modports:
//   master  the stream source; it drives din, din_valid and sync and
//           observes the results
//   slave   the demultiplexer
interface tdm_demux16_if;
  logic        din;
  logic        din_valid;
  logic        sync;
  logic [15:0] ch_out;
  logic        frame_valid;
  logic [4:0]  sel;
  logic        sync_err;
  logic        parity_err;

  modport master (
    output din, din_valid, sync,
    input  ch_out, frame_valid, sel, sync_err, parity_err
  );

  modport slave (
    input  din, din_valid, sync,
    output ch_out, frame_valid, sel, sync_err, parity_err
  );
endinterface

// File: rtl/tdm_demux16.sv
// tdm_demux16
// A 16-channel serial TDM demultiplexer.
// It locks onto a frame using the sync marker and collects one bit per
// valid slot into a shadow register. When a frame completes and is good,
// the block publishes that frame on ch_out.
//
// Ports:
//   clk    sole clock; all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    tdm_demux16_if.slave. Carries:
//            inputs:  din, din_valid, sync
//            outputs: ch_out, frame_valid, sel, sync_err, parity_err
//
// Configuration:
//   TDM_DEMUX16_PARITY_EN  When defined, each frame is 17 slots long.
//                          Slot 16 carries even parity over slots 0..15,
//                          and a failing frame raises parity_err.
//                          When undefined, each frame is 16 slots long
//                          and parity_err is tied low.
module tdm_demux16 (
  input logic          clk,
  input logic          rst_n,
  tdm_demux16_if.slave bus
);

`ifdef TDM_DEMUX16_PARITY_EN
  localparam logic [4:0] LAST_SLOT = 5'd16;
`else
  localparam logic [4:0] LAST_SLOT = 5'd15;
`endif

  typedef enum logic {HUNT, RECV} state_t;

  state_t      state;
  logic [4:0]  sel;
  logic [15:0] shadow;
  logic [15:0] ch_out;
  logic        frame_valid;
  logic        sync_err;
  logic [15:0] frame_word;
  logic        frame_good;

  // frame_word is the shadow register with the current beat merged into
  // its slot. This lets the final data beat be published in the same
  // cycle it is captured. The parity slot (16) has no data bit, so for
  // that slot frame_word equals shadow.
  always_comb begin
    frame_word = shadow;
    if (sel <= 5'd15) begin
      frame_word[sel[3:0]] = bus.din;
    end
  end

`ifdef TDM_DEMUX16_PARITY_EN
  logic parity_err;

  // Even parity: the 16 data bits together with the parity bit must hold
  // an even number of ones.
  assign frame_good = ~(^{frame_word, bus.din});
`else
  assign frame_good = 1'b1;
`endif

  // Framing FSM.
  // The error and frame pulses default low every cycle, so each lasts
  // exactly one cycle. Beats with din_valid low leave all state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sel         <= 5'd0;
      shadow      <= 16'h0000;
      ch_out      <= 16'h0000;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX16_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX16_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            if (bus.sync) begin
              shadow <= {15'd0, bus.din};
              sel    <= 5'd1;
              state  <= RECV;
            end
          end
          RECV: begin
            if (bus.sync) begin
              // A sync that arrives mid-frame restarts the frame at
              // slot 0. A sync that arrives exactly at slot 0 is the
              // normal frame start.
              sync_err <= (sel != 5'd0);
              shadow   <= {15'd0, bus.din};
              sel      <= 5'd1;
            end else if (sel == 5'd0) begin
              // Slot 0 arrived without its sync marker, so lock is lost.
              sync_err <= 1'b1;
              state    <= HUNT;
            end else begin
              shadow <= frame_word;
              if (sel == LAST_SLOT) begin
                sel <= 5'd0;
                if (frame_good) begin
                  ch_out      <= frame_word;
                  frame_valid <= 1'b1;
                end
`ifdef TDM_DEMUX16_PARITY_EN
                else begin
                  parity_err <= 1'b1;
                end
`endif
              end else begin
                sel <= sel + 5'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.ch_out      = ch_out;
  assign bus.frame_valid = frame_valid;
  assign bus.sel         = sel;
  assign bus.sync_err    = sync_err;
`ifdef TDM_DEMUX16_PARITY_EN
  assign bus.parity_err  = parity_err;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16
// Self-checking bench for tdm_demux16.
//
// Structure:
//   - a table of fixed vectors
//   - hand-written multi-cycle sequences
//   - a randomized run
//
// The sequences and the random run are compared against a frame-level
// reference model. The model collects beats in a queue and evaluates a
// whole frame at once.
//
// Configuration:
//   TDM_DEMUX16_PARITY_EN  switches the bench to 17-slot frames and
//                          enables the parity cases.
module tb_tdm_demux16;

`ifdef TDM_DEMUX16_PARITY_EN
  localparam int L = 17;
`else
  localparam int L = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tdm_demux16_if bus();

  tdm_demux16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fv_seen = 0;
  int se_seen = 0;

  // Reference model state.
  // m_hunt is set while no sync has been seen.
  // m_q holds the bits of the current frame.
  // An empty queue outside hunt means the next beat must carry sync.
  bit          m_hunt;
  bit          m_q[$];
  logic [15:0] m_ch;
  bit          m_fv, m_se, m_pe;

  function automatic void model_reset();
    m_hunt = 1'b1;
    m_q.delete();
    m_ch = 16'h0000;
    m_fv = 1'b0;
    m_se = 1'b0;
    m_pe = 1'b0;
  endfunction

  function automatic void model_beat(bit d, bit v, bit s);
    m_fv = 1'b0;
    m_se = 1'b0;
    m_pe = 1'b0;
    if (!v) return;
    if (m_hunt) begin
      if (s) begin
        m_q.delete();
        m_q.push_back(d);
        m_hunt = 1'b0;
      end
      return;
    end
    if (s) begin
      if (m_q.size() != 0) m_se = 1'b1;
      m_q.delete();
      m_q.push_back(d);
      return;
    end
    if (m_q.size() == 0) begin
      m_se = 1'b1;
      m_hunt = 1'b1;
      return;
    end
    m_q.push_back(d);
    if (m_q.size() == L) begin
      int ones;
      int unsigned val;
      ones = 0;
      val = 0;
      for (int i = 0; i < L; i++) ones += int'(m_q[i]);
      for (int i = 0; i < 16; i++) val += int'(m_q[i]) * (1 << i);
      if ((L == 17) && (ones % 2 != 0)) begin
        m_pe = 1'b1;
      end else begin
        m_ch = val[15:0];
        m_fv = 1'b1;
      end
      m_q.delete();
    end
  endfunction

  task automatic check_output(string name, logic [15:0] ch, bit fv, logic [4:0] s,
                              bit se, bit pe);
    checks++;
    if (bus.ch_out !== ch || bus.frame_valid !== fv || bus.sel !== s ||
        bus.sync_err !== se || bus.parity_err !== pe) begin
      failures++;
      $display("[TB] FAIL %s: got ch_out=%h frame_valid=%b sel=%0d sync_err=%b parity_err=%b, expected ch_out=%h frame_valid=%b sel=%0d sync_err=%b parity_err=%b",
               name, bus.ch_out, bus.frame_valid, bus.sel, bus.sync_err, bus.parity_err,
               ch, fv, s, se, pe);
    end
  endtask

  task automatic check_value(string name, int got, int expected);
    checks++;
    if (got != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, got, got, expected, expected);
    end
  endtask

  // Drive one cycle of inputs away from the sampling edge, then let the
  // model consume the same beat. Outputs are sampled 1 time unit after
  // the rising edge.
  task automatic apply_stimulus(bit d, bit v, bit s);
    @(negedge clk);
    bus.din = d;
    bus.din_valid = v;
    bus.sync = s;
    @(posedge clk);
    #1;
    model_beat(d, v, s);
    if (bus.frame_valid === 1'b1) fv_seen++;
    if (bus.sync_err === 1'b1) se_seen++;
  endtask

  task automatic step(string name, bit d, bit v, bit s);
    apply_stimulus(d, v, s);
    check_output(name, m_ch, m_fv, 5'(m_q.size()), m_se, m_pe);
  endtask

  // Send one sync-started frame, optionally with an idle gap after beat
  // gap_after and optionally with an inverted parity bit.
  task automatic send_frame(string name, logic [15:0] data, int gap_after,
                            int gap_len, bit par_flip);
    for (int i = 0; i < L; i++) begin
      bit d;
      d = (i < 16) ? data[i[3:0]] : ((^data) ^ par_flip);
      step(name, d, 1'b1, i == 0);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          step(name, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end
      end
    end
  endtask

  typedef struct {
    bit          din;
    bit          valid;
    bit          sync;
    logic [15:0] ch;
    bit          fv;
    logic [4:0]  sel;
    bit          se;
    bit          pe;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] word;
    vec_t v;

    // Vector table:
    //   1. one A5C3 frame
    //   2. a missing sync after the frame
    //   3. an ignored idle beat
    //   4. an ignored hunt beat
    word = 16'hA5C3;
    for (int i = 0; i < L; i++) begin
      v.din   = (i < 16) ? word[i[3:0]] : (^word);
      v.valid = 1'b1;
      v.sync  = (i == 0);
      v.fv    = (i == L - 1);
      v.ch    = (i == L - 1) ? 16'hA5C3 : 16'h0000;
      v.sel   = (i == L - 1) ? 5'd0 : 5'(i + 1);
      v.se    = 1'b0;
      v.pe    = 1'b0;
      tbl.push_back(v);
    end
    tbl.push_back('{din: 1'b1, valid: 1'b1, sync: 1'b0, ch: 16'hA5C3, fv: 1'b0,
                    sel: 5'd0, se: 1'b1, pe: 1'b0});
    tbl.push_back('{din: 1'b1, valid: 1'b0, sync: 1'b1, ch: 16'hA5C3, fv: 1'b0,
                    sel: 5'd0, se: 1'b0, pe: 1'b0});
    tbl.push_back('{din: 1'b0, valid: 1'b1, sync: 1'b0, ch: 16'hA5C3, fv: 1'b0,
                    sel: 5'd0, se: 1'b0, pe: 1'b0});

    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0);
    // Release reset at an arbitrary phase.
    @(negedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i].din, tbl[i].valid, tbl[i].sync);
      check_output($sformatf("table_%0d", i), tbl[i].ch, tbl[i].fv, tbl[i].sel,
                   tbl[i].se, tbl[i].pe);
    end

    // Two back-to-back frames, with a 3-cycle gap inside the second.
    fv_seen = 0;
    send_frame("b2b_f1", 16'h0001, -1, 0, 1'b0);
    send_frame("b2b_f2", 16'h8000, 5, 3, 1'b0);
    check_value("b2b_fv_pulses", fv_seen, 2);
    check_value("b2b_ch_out", int'(bus.ch_out), 32'h8000);

    // Sync on beat 9: the partial frame is dropped and the restarted
    // frame completes.
    fv_seen = 0;
    se_seen = 0;
    for (int i = 0; i < 9; i++) step("early_sync_part", 1'b1, 1'b1, i == 0);
    send_frame("early_sync_frame", 16'h1234, -1, 0, 1'b0);
    check_value("early_sync_err_pulses", se_seen, 1);
    check_value("early_sync_fv_pulses", fv_seen, 1);
    check_value("early_sync_ch_out", int'(bus.ch_out), 32'h1234);

    // Missing sync after a complete frame. The block returns to hunt, and
    // ch_out holds until the next sync-started frame.
    step("lost_sync", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("hunt_ignore", 1'b1, 1'b1, 1'b0);
    check_value("hunt_ch_held", int'(bus.ch_out), 32'h1234);
    send_frame("relock_frame", 16'h5A5A, -1, 0, 1'b0);

    // Reset after beat 7. It takes effect without a clock edge, and the
    // rest of the frame is ignored.
    for (int i = 0; i < 8; i++) step("pre_reset", 1'b0, 1'b1, i == 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset", 16'h0000, 1'b0, 5'd0, 1'b0, 1'b0);
    model_reset();
    #4 rst_n = 1'b1;
    for (int i = 8; i < 16; i++) step("post_reset", 1'b1, 1'b1, 1'b0);
    check_value("post_reset_ch_out", int'(bus.ch_out), 0);

`ifdef TDM_DEMUX16_PARITY_EN
    // A good parity bit publishes the frame. A bad parity bit drops the
    // frame and leaves ch_out unchanged.
    send_frame("parity_good", 16'h0007, -1, 0, 1'b0);
    check_value("parity_good_ch", int'(bus.ch_out), 32'h0007);
    send_frame("parity_bad", 16'h00F0, -1, 0, 1'b1);
    check_value("parity_bad_ch", int'(bus.ch_out), 32'h0007);
`endif

    // Randomized run. Sync is likely at slot 0 and rare elsewhere; valid
    // is high most of the time.
    for (int n = 0; n < 3000; n++) begin
      bit rv, rs, rd;
      rv = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      if (m_q.size() == 0) rs = ($urandom_range(0, 9) != 0);
      else rs = ($urandom_range(0, 39) == 0);
      step("random", rd, rv, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port din, input, 1 bit, time-multiplexed serial data, one channel bit per valid slot.
REQ-004 SHALL have port din_valid, input, 1 bit, qualifies din and sync; inputs ignored when low.
REQ-005 SHALL have port sync, input, 1 bit, marks channel-0 slot of a frame, sampled only with din_valid.
REQ-006 SHALL have port ch_out, output, 16 bits, last good frame, bit n = channel n.
REQ-007 SHALL have port frame_valid, output, 1 bit, one-cycle pulse when ch_out updates.
REQ-008 SHALL have port sel, output, 5 bits, slot index expected on next valid beat.
REQ-009 SHALL have port sync_err, output, 1 bit, one-cycle pulse on framing violation.
REQ-010 SHALL have port parity_err, output, 1 bit, one-cycle pulse on parity failure.

Function
REQ-011 SHALL implement FSM states HUNT and RECV; HUNT after reset.
REQ-012 HUNT: valid beat without sync SHALL be discarded; valid beat with sync SHALL store din in shadow[0], set sel=1, enter RECV.
REQ-013 RECV: valid beat with sel in 1..L-1 and sync low SHALL store din in shadow slot sel, then sel+1 (L = frame length, REQ-021/022).
REQ-014 RECV: valid beat with sync high and sel!=0 SHALL pulse sync_err, discard partial frame, store din as slot 0, set sel=1.
REQ-015 RECV: valid beat with sel==0 and sync low SHALL pulse sync_err, discard, set sel=0, enter HUNT.
REQ-016 RECV: valid beat with sel==0 and sync high SHALL store slot 0, set sel=1.
REQ-017 On capture of slot L-1: sel SHALL wrap to 0, FSM stays RECV; if frame good, ch_out SHALL load all 16 data bits (including the bit on this beat) and frame_valid SHALL pulse, both registered, visible the cycle after that beat (latency 1).
REQ-018 ch_out SHALL hold its value between frames and on discarded frames.
REQ-019 Cycles with din_valid low SHALL change no state; gaps mid-frame are legal.
REQ-020 frame_valid, sync_err, parity_err SHALL be registered and never high longer than one cycle per event.

Configuration
REQ-021 Macro TDM_DEMUX16_PARITY_EN defined: L=17; slot 16 SHALL carry even parity over slots 0..15; on mismatch frame discarded, parity_err pulses, frame_valid stays low, sel wraps to 0, FSM stays RECV.
REQ-022 Macro undefined: L=16; parity_err SHALL be tied 0; port list unchanged.

Reset
REQ-023 rst_n low SHALL immediately set FSM=HUNT, sel=0, ch_out=16'h0000, frame_valid=0, sync_err=0, parity_err=0, shadow cleared.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release block SHALL require a new sync.
REQ-025 Reset release SHALL be safe at any clk phase; first edge after release behaves as HUNT.

Verification
REQ-026 Reset, then 16 (parity off) valid beats, sync on beat 0, bits = 16'hA5C3 LSB first -> one cycle after last beat ch_out=16'hA5C3, frame_valid=1 for one cycle, sel=0.
REQ-027 Two back-to-back frames 16'h0001 then 16'h8000, din_valid low 3 cycles between beats 5 and 6 of frame 2 -> two frame_valid pulses, ch_out ends 16'h8000.
REQ-028 Sync asserted on beat 9 of a frame -> sync_err pulse, no frame_valid, following 16 beats 16'h1234 -> ch_out=16'h1234.
REQ-029 Frame completes, next valid beat has sync low -> sync_err pulse, FSM HUNT, ch_out unchanged until next sync-started frame.
REQ-030 rst_n pulsed low after beat 7 -> all outputs zero asynchronously; remaining beats without sync ignored; ch_out stays 16'h0000.
REQ-031 With TDM_DEMUX16_PARITY_EN: data 16'h0007, parity bit 1 -> ch_out=16'h0007, frame_valid; parity bit 0 -> parity_err pulse, ch_out unchanged.
